// File: rtl/iddr_word_aligner.sv
// rtl/iddr_word_aligner.sv - nibble-to-word assembler with bit-slip training alignment
// Slides an 8-bit window over the last three DDR nibbles until TRAIN_PATTERN repeats MATCH_COUNT times.
module iddr_word_aligner #(
  parameter logic [7:0] TRAIN_PATTERN = 8'hB4,
  parameter int         MATCH_COUNT   = 4,
  parameter int         SLIP_WAIT     = 2,
  parameter int         MAX_SLIPS     = 16
) (
  input  logic       SCLKB,
  input  logic       RSTAILB,
  input  logic       QA0,
  input  logic       QB0,
  input  logic       QA1,
  input  logic       QB1,
  input  logic       LOCK,
  input  logic       ALIGN_EN,
  input  logic       ALIGN_RESTART,
  input  logic       TRAIN_MODE,
  output logic [7:0] WORD,
  output logic       WORD_VALID,
  output logic       ALIGNED,
  output logic       ALIGN_FAIL,
  output logic [7:0] ERR_COUNT,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_CONFIRM = 2'd2,
    S_ALIGNED = 2'd3
  } state_t;

  state_t      state_q;
  logic [11:0] hist_q;
  logic [11:0] hist_d;
  logic [2:0]  off_q;
  logic [2:0]  off_d;
  logic        phase_q;
  logic        lock_m_q;
  logic        lock_s_q;
  logic [7:0]  slip_cnt_q;
  logic [3:0]  match_cnt_q;
  logic [2:0]  wait_cnt_q;
  logic [7:0]  word_q;
  logic [7:0]  err_cnt_q;
  logic        valid_q;
  logic        aligned_q;
  logic        fail_q;
  logic [7:0]  cand;
  logic        slot;
  logic        is_match;
  logic        force_idle;

  // Newest nibble enters at the top so bit0 of the window is always the earliest bit.
  assign hist_d     = {QA1, QB1, QA0, QB0, hist_q[11:4]};
  assign off_d      = off_q + 3'd1;
  assign cand       = hist_q[off_q[1:0] +: 8];
  assign slot       = (phase_q == off_q[2]) && (wait_cnt_q == 3'd0);
  assign is_match   = (cand == TRAIN_PATTERN);
  assign force_idle = ALIGN_RESTART || !ALIGN_EN || !lock_s_q;

  always_ff @(posedge SCLKB or posedge RSTAILB) begin
    if (RSTAILB) begin
      hist_q   <= 12'd0;
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      lock_m_q <= LOCK;
      lock_s_q <= lock_m_q;
    end
  end

  always_ff @(posedge SCLKB or posedge RSTAILB) begin
    if (RSTAILB) begin
      state_q     <= S_IDLE;
      off_q       <= 3'd0;
      phase_q     <= 1'b0;
      slip_cnt_q  <= 8'd0;
      match_cnt_q <= 4'd0;
      wait_cnt_q  <= 3'd0;
      word_q      <= 8'd0;
      valid_q     <= 1'b0;
      aligned_q   <= 1'b0;
      fail_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      valid_q   <= 1'b0;
      aligned_q <= 1'b0;
      phase_q   <= (state_q == S_IDLE) ? 1'b0 : ~phase_q;
      if (wait_cnt_q != 3'd0)
        wait_cnt_q <= wait_cnt_q - 3'd1;
      if (state_q == S_IDLE) begin
        off_q       <= 3'd0;
        slip_cnt_q  <= 8'd0;
        match_cnt_q <= 4'd0;
      end
      // Restart, disable and lock loss win over any slot decision on the same edge.
      if (force_idle) begin
        state_q <= S_IDLE;
        if (ALIGN_RESTART) begin
          fail_q    <= 1'b0;
          err_cnt_q <= 8'd0;
        end
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_SEARCH;
          S_SEARCH: if (slot) begin
            if (is_match) begin
              match_cnt_q <= 4'd1;
              if (MATCH_COUNT == 1) begin
                state_q   <= S_ALIGNED;
                aligned_q <= 1'b1;
              end else begin
                state_q <= S_CONFIRM;
              end
            end else begin
              off_q      <= off_d;
              wait_cnt_q <= 3'(SLIP_WAIT);
              if (int'(slip_cnt_q) + 1 >= MAX_SLIPS) begin
                fail_q     <= 1'b1;
                slip_cnt_q <= 8'd0;
              end else begin
                slip_cnt_q <= slip_cnt_q + 8'd1;
              end
            end
          end
          S_CONFIRM: if (slot) begin
            if (is_match) begin
              match_cnt_q <= match_cnt_q + 4'd1;
              if (int'(match_cnt_q) + 1 >= MATCH_COUNT) begin
                state_q   <= S_ALIGNED;
                aligned_q <= 1'b1;
              end
            end else begin
              state_q     <= S_SEARCH;
              match_cnt_q <= 4'd0;
              off_q       <= off_d;
              wait_cnt_q  <= 3'(SLIP_WAIT);
            end
          end
          default: begin
            aligned_q <= 1'b1;
            if (slot) begin
              word_q  <= cand;
              valid_q <= 1'b1;
              if (TRAIN_MODE && !is_match && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        endcase
      end
    end
  end

  assign WORD       = word_q;
  assign WORD_VALID = valid_q;
  assign ALIGNED    = aligned_q;
  assign ALIGN_FAIL = fail_q;
  assign ERR_COUNT  = err_cnt_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_iddr_word_aligner.sv
// tb/tb_iddr_word_aligner.sv - randomized bench for iddr_word_aligner against a bit-stream reference model
// The model indexes an absolute received-bit history instead of shifting registers.
module tb_iddr_word_aligner;

  localparam logic [7:0] PAT = 8'hB4;
  localparam int MC = 4;
  localparam int SW = 2;
  localparam int MS = 16;

  logic       clk;
  logic       rst;
  logic       qa0, qb0, qa1, qb1;
  logic       lock, en, restart, train;
  logic [7:0] word;
  logic       word_valid, aligned, fail;
  logic [7:0] err;
  logic [1:0] state;

  iddr_word_aligner #(
    .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC), .SLIP_WAIT(SW), .MAX_SLIPS(MS)
  ) dut (
    .SCLKB(clk), .RSTAILB(rst),
    .QA0(qa0), .QB0(qb0), .QA1(qa1), .QB1(qb1),
    .LOCK(lock), .ALIGN_EN(en), .ALIGN_RESTART(restart), .TRAIN_MODE(train),
    .WORD(word), .WORD_VALID(word_valid), .ALIGNED(aligned),
    .ALIGN_FAIL(fail), .ERR_COUNT(err), .STATE(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Transmit side: words go out LSB first; a zero prefix sets the true word boundary.
  bit tx_q[$];
  int word_q[$];
  int fill_mode = 0;

  function automatic int next_fill();
    if (fill_mode == 1) return 0;
    if (fill_mode == 2 && $urandom_range(0, 7) == 0) return int'($urandom_range(0, 255));
    return int'(PAT);
  endfunction

  task automatic next_nib(output logic [3:0] nib);
    while (tx_q.size() < 4) begin
      int w;
      w = (word_q.size() != 0) ? word_q.pop_front() : next_fill();
      for (int i = 0; i < 8; i++) tx_q.push_back(w[i]);
    end
    for (int i = 0; i < 4; i++) nib[i] = tx_q.pop_front();
  endtask

  // Reference model: rx_bits holds every bit received since reset, preceded by 12 zeros.
  bit rx_bits[$];
  bit lock_log[$];
  int m_state, m_off, m_enter, m_hold, m_slips, m_matches;
  int m_fail, m_err, m_word, m_valid;

  task automatic model_reset();
    edge_n = 0;
    m_state = 0; m_off = 0; m_enter = 0; m_hold = 0; m_slips = 0; m_matches = 0;
    m_fail = 0; m_err = 0; m_word = 0; m_valid = 0;
    rx_bits.delete();
    lock_log.delete();
    for (int i = 0; i < 12; i++) rx_bits.push_back(1'b0);
  endtask

  function automatic int window(input int shift);
    int w;
    int base;
    w = 0;
    base = rx_bits.size() - 12 + shift;
    for (int i = 0; i < 8; i++) w = w | (int'(rx_bits[base + i]) << i);
    return w;
  endfunction

  task automatic slip();
    m_off  = (m_off + 1) % 8;
    m_hold = edge_n + SW + 1;
  endtask

  task automatic model_edge(input logic [3:0] nib);
    int cand;
    bit lk, is_slot, hit, go_idle;
    edge_n++;
    lk      = (edge_n >= 3) ? lock_log[edge_n - 3] : 1'b0;
    cand    = window(m_off % 4);
    hit     = (cand == int'(PAT));
    is_slot = (m_state != 0) && (((edge_n - m_enter - 1) % 2) == (m_off / 4)) && (edge_n >= m_hold);
    go_idle = restart || !en || !lk;
    m_valid = 0;
    if (go_idle) begin
      m_state = 0;
      if (restart) begin m_fail = 0; m_err = 0; end
    end else if (m_state == 0) begin
      m_state = 1; m_enter = edge_n; m_off = 0; m_slips = 0; m_matches = 0;
    end else if (is_slot) begin
      if (m_state == 1) begin
        if (hit) begin
          m_matches = 1;
          m_state = (MC == 1) ? 3 : 2;
        end else begin
          slip();
          m_slips++;
          if (m_slips == MS) begin m_fail = 1; m_slips = 0; end
        end
      end else if (m_state == 2) begin
        if (hit) begin
          m_matches++;
          if (m_matches == MC) m_state = 3;
        end else begin
          m_state = 1; m_matches = 0;
          slip();
        end
      end else begin
        m_word = cand;
        m_valid = 1;
        if (train && !hit && m_err < 255) m_err++;
      end
    end
    lock_log.push_back(lock);
    for (int i = 0; i < 4; i++) rx_bits.push_back(nib[i]);
  endtask

  task automatic compare_all();
    check("state", int'(state), m_state);
    check("aligned", int'(aligned), int'(m_state == 3));
    check("word_valid", int'(word_valid), m_valid);
    check("word", int'(word), m_word);
    check("align_fail", int'(fail), m_fail);
    check("err_count", int'(err), m_err);
  endtask

  task automatic step();
    logic [3:0] nib;
    next_nib(nib);
    {qa1, qb1, qa0, qb0} = nib;
    @(posedge clk);
    model_edge(nib);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int prefix);
    rst = 1'b1;
    model_reset();
    tx_q.delete();
    word_q.delete();
    for (int i = 0; i < prefix; i++) tx_q.push_back(1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"}, int'(word), 0);
    check({tag, "_valid"}, int'(word_valid), 0);
    check({tag, "_aligned"}, int'(aligned), 0);
    check({tag, "_fail"}, int'(fail), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_state"}, int'(state), 0);
  endtask

  int n, cnt, back_edge;

  initial begin
    rst = 1'b1; lock = 1'b1; en = 1'b1; restart = 1'b0; train = 1'b0;
    {qa1, qb1, qa0, qb0} = 4'd0;
    #2;
    check_all_zero("reset");

    // 1: boundary five bits in, found after slipping through offsets 0..5
    fill_mode = 0;
    do_reset(5);
    n = 0;
    while (aligned != 1'b1 && n < 100) begin step(); n++; end
    check("t1_align_edge", edge_n, 29);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt += int'(word_valid); end
    check("t1_valid_rate", cnt, 5);
    check("t1_word", int'(word), int'(PAT));
    check("t1_err", int'(err), 0);

    // 2: corrupted training words are counted and shown, count saturates
    train = 1'b1;
    for (int i = 0; i < 3; i++) word_q.push_back(int'(8'hB5));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (word_valid && word == 8'hB5) cnt++;
    end
    check("t2_b5_words", cnt, 3);
    check("t2_err3", int'(err), 3);
    check("t2_aligned", int'(aligned), 1);
    for (int i = 0; i < 300; i++) word_q.push_back(int'(8'hB5));
    for (int i = 0; i < 700; i++) step();
    check("t2_err_sat", int'(err), 255);
    check("t2_aligned_sat", int'(aligned), 1);
    train = 1'b0;

    // 3: no pattern at all, failure flag after MAX_SLIPS slips
    fill_mode = 1;
    do_reset(0);
    n = 0;
    while (fail != 1'b1 && n < 200) begin step(); n++; end
    check("t3_fail_edge", edge_n, 61);
    check("t3_state", int'(state), 1);
    for (int i = 0; i < 10; i++) step();
    check("t3_fail_sticky", int'(fail), 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("t3_restart_state", int'(state), 0);
    check("t3_restart_fail", int'(fail), 0);
    step();
    check("t3_resume_state", int'(state), 1);

    // 4: one missing pattern word during CONFIRM
    fill_mode = 0;
    do_reset(5);
    for (int i = 0; i < 11; i++) word_q.push_back(int'(PAT));
    word_q.push_back(0);
    n = 0;
    while (state != 2'd2 && n < 100) begin step(); n++; end
    check("t4_reach_confirm", int'(state), 2);
    cnt = 0; back_edge = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt += int'(word_valid);
      if (state == 2'd1 && back_edge < 0) back_edge = edge_n;
    end
    check("t4_search_edge", back_edge, 27);
    check("t4_no_valid", cnt, 0);

    // 5: one-cycle lock loss, realign, then async reset mid-CONFIRM
    do_reset(5);
    n = 0;
    while (aligned != 1'b1 && n < 100) begin step(); n++; end
    for (int i = 0; i < 6; i++) step();
    lock = 1'b0;
    step();
    lock = 1'b1;
    n = 1;
    while (state != 2'd0 && n < 10) begin step(); n++; end
    check("t5_idle_delay", n, 3);
    check("t5_valid_idle", int'(word_valid), 0);
    n = 0;
    while (aligned != 1'b1 && n < 100) begin step(); n++; end
    check("t5_realigned", int'(aligned), 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    n = 0;
    while (state != 2'd2 && n < 100) begin step(); n++; end
    check("t5_confirm", int'(state), 2);
    #3 rst = 1'b1;
    #1;
    check_all_zero("t5_async");

    // 6: restart coincides with the final CONFIRM match
    do_reset(5);
    for (int i = 0; i < 28; i++) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("t6_state", int'(state), 0);
    check("t6_aligned", int'(aligned), 0);
    step();
    check("t6_aligned_next", int'(aligned), 0);

    // Random traffic with sporadic restarts, enable drops and lock glitches
    fill_mode = 2;
    do_reset(int'($urandom_range(0, 7)));
    for (int i = 0; i < 1500; i++) begin
      restart = ($urandom_range(0, 99) == 0);
      en      = ($urandom_range(0, 199) != 0);
      lock    = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) train = ~train;
      step();
    end
    restart = 1'b0; en = 1'b1; lock = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
